// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO family.
// count_width : bits needed to hold 0..depth
// ptr_inc     : pointer increment with wrap at depth-1 (non-power-of-2 depths)
// params_ok   : parameter legality check reused by FIFO variants
package fifo_pkg;

  typedef enum logic {ModeStd, ModeFwft} read_mode_e;

  function automatic int unsigned count_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic bit params_ok(int unsigned width, int unsigned depth,
                                   int unsigned asize, int unsigned af,
                                   int unsigned ae, int unsigned fwft);
    if (width < 1 || depth < 2) return 1'b0;
    if (asize < 1 || asize > 30) return 1'b0;
    if ((32'd1 << asize) < depth) return 1'b0;
    if (count_width(depth) > asize + 1) return 1'b0;
    if (af < 1 || af > depth) return 1'b0;
    if (ae > depth - 1) return 1'b0;
    if (fwft > 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/fifo_synch_param_if.sv
// Handshake/status bundle of fifo_synch_param.
// master : producer/consumer side (drives clr, w_en, wdata, r_en)
// slave  : FIFO side (drives rdata, count and all flags)
interface fifo_synch_param_if #(
  parameter int unsigned MEMORY_WIDTH = 8,
  parameter int unsigned ADDRESS_SIZE = 4
);
  logic                    clr;
  logic                    w_en;
  logic [MEMORY_WIDTH-1:0] wdata;
  logic                    r_en;
  logic [MEMORY_WIDTH-1:0] rdata;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [ADDRESS_SIZE:0]   count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output clr, w_en, wdata, r_en,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, w_en, wdata, r_en,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_wrap_ptr.sv
// Wrapping pointer counter: counts 0..MEMORY_DEPTH-1 then back to 0.
// Ports: clk, rst (async, active-high), clr (sync to 0), en (advance), ptr (current value)
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = 4,
  parameter int unsigned MEMORY_DEPTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  output logic [ADDRESS_SIZE-1:0] ptr
);

  logic [ADDRESS_SIZE-1:0] ptr_next;

  always_comb begin
    ptr_next = ADDRESS_SIZE'(ptr_inc(32'(ptr), MEMORY_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/fifo_synch_param.sv
// Single-clock parametrised FIFO with fill count, almost-full/empty thresholds,
// sticky overflow/underflow, synchronous flush and standard or FWFT read mode.
// Ports: clk, rst (async, active-high), bus (slave side of fifo_synch_param_if:
// clr, w_en, wdata, r_en in; rdata, full, empty, almost_full, almost_empty,
// count, overflow, underflow out). All status outputs are registered.
module fifo_synch_param
  import fifo_pkg::*;
#(
  parameter int unsigned MEMORY_WIDTH = 8,
  parameter int unsigned MEMORY_DEPTH = 12,
  parameter int unsigned ADDRESS_SIZE = 4,
  parameter int unsigned AF_THRESH    = 10,
  parameter int unsigned AE_THRESH    = 2,
  parameter int unsigned FWFT         = 0
) (
  input logic               clk,
  input logic               rst,
  fifo_synch_param_if.slave bus
);

  if (!params_ok(MEMORY_WIDTH, MEMORY_DEPTH, ADDRESS_SIZE, AF_THRESH, AE_THRESH, FWFT))
  begin : g_param_err
    $error("fifo_synch_param: illegal parameter combination");
  end

  localparam int unsigned CountW = ADDRESS_SIZE + 1;
  typedef logic [CountW-1:0] count_t;
  localparam count_t     DepthCnt = count_t'(MEMORY_DEPTH);
  localparam count_t     AfCnt    = count_t'(AF_THRESH);
  localparam count_t     AeCnt    = count_t'(AE_THRESH);
  localparam read_mode_e Mode     = (FWFT != 0) ? ModeFwft : ModeStd;

  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [ADDRESS_SIZE-1:0] w_ptr;
  logic [ADDRESS_SIZE-1:0] r_ptr;
  count_t                  count_q;
  count_t                  count_d;
  logic                    full_q;
  logic                    empty_q;
  logic                    af_q;
  logic                    ae_q;
  logic                    ovf_q;
  logic                    unf_q;
  logic                    wa;
  logic                    ra;

  // When full, a write only fits alongside a read; flags are registered so
  // the decision uses last-edge state, never the current request.
  always_comb begin
    wa      = bus.w_en && (!full_q || bus.r_en) && !bus.clr;
    ra      = bus.r_en && !empty_q && !bus.clr;
    count_d = count_q;
    if (bus.clr) begin
      count_d = '0;
    end else if (wa && !ra) begin
      count_d = count_q + 1'b1;
    end else if (ra && !wa) begin
      count_d = count_q - 1'b1;
    end
  end

  fifo_wrap_ptr #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_w_ptr (
    .clk(clk),
    .rst(rst),
    .clr(bus.clr),
    .en (wa),
    .ptr(w_ptr)
  );

  fifo_wrap_ptr #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_r_ptr (
    .clk(clk),
    .rst(rst),
    .clr(bus.clr),
    .en (ra),
    .ptr(r_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == DepthCnt);
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= AfCnt);
      ae_q    <= (count_d <= AeCnt);
      if (bus.clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (bus.w_en && !wa) ovf_q <= 1'b1;
        if (bus.r_en && !ra) unf_q <= 1'b1;
      end
    end
  end

  // Storage is not reset. Non-blocking write gives read-before-write when a
  // full FIFO reads and writes the same slot.
  always_ff @(posedge clk) begin
    if (wa) begin
      mem[w_ptr] <= bus.wdata;
    end
  end

  if (Mode == ModeFwft) begin : g_fwft
    // Head word is visible whenever data is present; zero while empty.
    always_comb begin
      bus.rdata = empty_q ? '0 : mem[r_ptr];
    end
  end else begin : g_std
    logic [MEMORY_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (ra) begin
        rdata_q <= mem[r_ptr];
      end
    end

    always_comb begin
      bus.rdata = rdata_q;
    end
  end

  always_comb begin
    bus.full         = full_q;
    bus.empty        = empty_q;
    bus.almost_full  = af_q;
    bus.almost_empty = ae_q;
    bus.count        = count_q;
    bus.overflow     = ovf_q;
    bus.underflow    = unf_q;
  end

endmodule

// File: tb/tb_fifo_synch_param.sv
// Directed bench for fifo_synch_param: one standard-mode instance (a) and one
// FWFT instance (b), both with default depth 12 / thresholds 10 and 2.
module tb_fifo_synch_param;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  fifo_synch_param_if #(.MEMORY_WIDTH(8), .ADDRESS_SIZE(4)) a ();
  fifo_synch_param_if #(.MEMORY_WIDTH(8), .ADDRESS_SIZE(4)) b ();

  fifo_synch_param #(.FWFT(0)) u_std (
    .clk(clk),
    .rst(rst),
    .bus(a)
  );

  fifo_synch_param #(.FWFT(1)) u_fwft (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a.clr = 0; a.w_en = 0; a.r_en = 0; a.wdata = '0;
    b.clr = 0; b.w_en = 0; b.r_en = 0; b.wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (a.count !== 5'd0) begin miscompares++; $display("FAIL rst_count act=%0d exp=0", a.count); end
    vectors++; if (a.empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty act=%b exp=1", a.empty); end
    vectors++; if (a.almost_empty !== 1'b1) begin miscompares++; $display("FAIL rst_ae act=%b exp=1", a.almost_empty); end
    vectors++; if (a.full !== 1'b0) begin miscompares++; $display("FAIL rst_full act=%b exp=0", a.full); end
    vectors++; if (a.almost_full !== 1'b0) begin miscompares++; $display("FAIL rst_af act=%b exp=0", a.almost_full); end
    vectors++; if (a.overflow !== 1'b0 || a.underflow !== 1'b0) begin miscompares++; $display("FAIL rst_err act=%b%b exp=00", a.overflow, a.underflow); end
    vectors++; if (a.rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata act=%h exp=00", a.rdata); end
    vectors++; if (b.empty !== 1'b1) begin miscompares++; $display("FAIL rst_fwft_empty act=%b exp=1", b.empty); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      a.w_en = 1; a.wdata = 8'(i);
      tick();
      vectors++; if (a.count !== 5'(i)) begin miscompares++; $display("FAIL fill_count[%0d] act=%0d exp=%0d", i, a.count, i); end
      vectors++; if (a.almost_full !== (i >= 10)) begin miscompares++; $display("FAIL fill_af[%0d] act=%b exp=%b", i, a.almost_full, i >= 10); end
      vectors++; if (a.full !== (i == 12)) begin miscompares++; $display("FAIL fill_full[%0d] act=%b exp=%b", i, a.full, i == 12); end
      vectors++; if (a.almost_empty !== (i <= 2)) begin miscompares++; $display("FAIL fill_ae[%0d] act=%b exp=%b", i, a.almost_empty, i <= 2); end
    end
    a.wdata = 8'hEE;
    tick();
    a.w_en = 0;
    vectors++; if (a.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set act=%b exp=1", a.overflow); end
    vectors++; if (a.count !== 5'd12) begin miscompares++; $display("FAIL ovf_count act=%0d exp=12", a.count); end
    for (int i = 1; i <= 12; i++) begin
      a.r_en = 1;
      tick();
      vectors++; if (a.rdata !== 8'(i)) begin miscompares++; $display("FAIL drain_data[%0d] act=%h exp=%h", i, a.rdata, 8'(i)); end
    end
    a.r_en = 0;
    vectors++; if (a.empty !== 1'b1 || a.almost_empty !== 1'b1) begin miscompares++; $display("FAIL drain_flags act=%b%b exp=11", a.empty, a.almost_empty); end
    vectors++; if (a.underflow !== 1'b0) begin miscompares++; $display("FAIL drain_unf act=%b exp=0", a.underflow); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a.w_en = 1; a.wdata = 8'(8'h20 + i);
      tick();
    end
    a.w_en = 0;
    for (int i = 0; i < 8; i++) begin
      a.r_en = 1;
      tick();
      vectors++; if (a.rdata !== 8'(8'h20 + i)) begin miscompares++; $display("FAIL wrap1_data[%0d] act=%h exp=%h", i, a.rdata, 8'(8'h20 + i)); end
    end
    a.r_en = 0;
    for (int i = 0; i < 10; i++) begin
      a.w_en = 1; a.wdata = 8'(8'h40 + i);
      tick();
      vectors++; if (a.count !== 5'(i + 1)) begin miscompares++; $display("FAIL wrap_count[%0d] act=%0d exp=%0d", i, a.count, i + 1); end
    end
    a.w_en = 0;
    for (int i = 0; i < 10; i++) begin
      a.r_en = 1;
      tick();
      vectors++; if (a.rdata !== 8'(8'h40 + i)) begin miscompares++; $display("FAIL wrap2_data[%0d] act=%h exp=%h", i, a.rdata, 8'(8'h40 + i)); end
    end
    a.r_en = 0;
    vectors++; if (a.empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty act=%b exp=1", a.empty); end
  endtask

  task automatic test_simul_full_empty();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      a.w_en = 1; a.wdata = 8'(8'h60 + i);
      tick();
    end
    a.r_en = 1; a.wdata = 8'h99;
    tick();
    a.w_en = 0; a.r_en = 0;
    vectors++; if (a.count !== 5'd12) begin miscompares++; $display("FAIL both_full_count act=%0d exp=12", a.count); end
    vectors++; if (a.rdata !== 8'h60) begin miscompares++; $display("FAIL both_full_rdata act=%h exp=60", a.rdata); end
    vectors++; if (a.overflow !== 1'b0) begin miscompares++; $display("FAIL both_full_ovf act=%b exp=0", a.overflow); end
    for (int i = 1; i <= 12; i++) begin
      a.r_en = 1;
      tick();
      vectors++; if (a.rdata !== ((i == 12) ? 8'h99 : 8'(8'h60 + i))) begin miscompares++; $display("FAIL both_drain[%0d] act=%h exp=%h", i, a.rdata, (i == 12) ? 8'h99 : 8'(8'h60 + i)); end
    end
    a.w_en = 1; a.wdata = 8'h77;
    tick();
    a.w_en = 0; a.r_en = 0;
    vectors++; if (a.count !== 5'd1) begin miscompares++; $display("FAIL both_empty_count act=%0d exp=1", a.count); end
    vectors++; if (a.underflow !== 1'b1) begin miscompares++; $display("FAIL both_empty_unf act=%b exp=1", a.underflow); end
    vectors++; if (a.rdata !== 8'h99) begin miscompares++; $display("FAIL both_empty_hold act=%h exp=99", a.rdata); end
    a.r_en = 1;
    tick();
    a.r_en = 0;
    vectors++; if (a.rdata !== 8'h77) begin miscompares++; $display("FAIL both_empty_word act=%h exp=77", a.rdata); end
  endtask

  task automatic test_fwft();
    do_reset();
    b.w_en = 1; b.wdata = 8'hA5;
    tick();
    b.w_en = 0;
    vectors++; if (b.empty !== 1'b0) begin miscompares++; $display("FAIL fwft_empty act=%b exp=0", b.empty); end
    vectors++; if (b.rdata !== 8'hA5) begin miscompares++; $display("FAIL fwft_rdata act=%h exp=a5", b.rdata); end
    tick();
    vectors++; if (b.rdata !== 8'hA5) begin miscompares++; $display("FAIL fwft_hold act=%h exp=a5", b.rdata); end
    b.r_en = 1;
    tick();
    b.r_en = 0;
    vectors++; if (b.empty !== 1'b1) begin miscompares++; $display("FAIL fwft_pop_empty act=%b exp=1", b.empty); end
    b.w_en = 1; b.wdata = 8'h11;
    tick();
    b.wdata = 8'h22;
    tick();
    b.w_en = 0;
    vectors++; if (b.rdata !== 8'h11) begin miscompares++; $display("FAIL fwft_head1 act=%h exp=11", b.rdata); end
    b.r_en = 1;
    tick();
    b.r_en = 0;
    vectors++; if (b.rdata !== 8'h22) begin miscompares++; $display("FAIL fwft_head2 act=%h exp=22", b.rdata); end
    vectors++; if (b.count !== 5'd1) begin miscompares++; $display("FAIL fwft_count act=%0d exp=1", b.count); end
  endtask

  task automatic test_clr();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      a.w_en = 1; a.wdata = 8'(8'h80 + i);
      tick();
    end
    a.w_en = 0;
    for (int i = 0; i < 5; i++) begin
      a.r_en = 1;
      tick();
    end
    a.r_en = 0;
    vectors++; if (a.count !== 5'd7 || a.overflow !== 1'b1) begin miscompares++; $display("FAIL clr_pre act=%0d/%b exp=7/1", a.count, a.overflow); end
    a.clr = 1; a.w_en = 1; a.r_en = 1; a.wdata = 8'hCC;
    tick();
    a.clr = 0; a.w_en = 0; a.r_en = 0;
    vectors++; if (a.count !== 5'd0) begin miscompares++; $display("FAIL clr_count act=%0d exp=0", a.count); end
    vectors++; if (a.empty !== 1'b1 || a.almost_empty !== 1'b1) begin miscompares++; $display("FAIL clr_empty act=%b%b exp=11", a.empty, a.almost_empty); end
    vectors++; if (a.overflow !== 1'b0 || a.underflow !== 1'b0) begin miscompares++; $display("FAIL clr_err act=%b%b exp=00", a.overflow, a.underflow); end
    vectors++; if (a.full !== 1'b0 || a.almost_full !== 1'b0) begin miscompares++; $display("FAIL clr_full act=%b%b exp=00", a.full, a.almost_full); end
    vectors++; if (a.rdata !== 8'h84) begin miscompares++; $display("FAIL clr_rdata act=%h exp=84", a.rdata); end
    a.w_en = 1; a.wdata = 8'h55;
    tick();
    a.w_en = 0; a.r_en = 1;
    tick();
    a.r_en = 0;
    vectors++; if (a.rdata !== 8'h55) begin miscompares++; $display("FAIL clr_after act=%h exp=55", a.rdata); end
  endtask

  task automatic test_async_rst();
    do_reset();
    a.r_en = 1;
    tick();
    a.r_en = 0;
    for (int i = 0; i < 3; i++) begin
      a.w_en = 1; a.wdata = 8'(8'h30 + i);
      tick();
    end
    a.w_en = 0; a.r_en = 1;
    tick();
    a.r_en = 0; a.w_en = 1; a.wdata = 8'h3F;
    tick();
    vectors++; if (a.rdata !== 8'h30 || a.underflow !== 1'b1) begin miscompares++; $display("FAIL arst_pre act=%h/%b exp=30/1", a.rdata, a.underflow); end
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (a.count !== 5'd0 || a.empty !== 1'b1 || a.almost_empty !== 1'b1) begin miscompares++; $display("FAIL arst_count act=%0d/%b%b exp=0/11", a.count, a.empty, a.almost_empty); end
    vectors++; if (a.full !== 1'b0 || a.almost_full !== 1'b0) begin miscompares++; $display("FAIL arst_full act=%b%b exp=00", a.full, a.almost_full); end
    vectors++; if (a.overflow !== 1'b0 || a.underflow !== 1'b0) begin miscompares++; $display("FAIL arst_err act=%b%b exp=00", a.overflow, a.underflow); end
    vectors++; if (a.rdata !== 8'h00) begin miscompares++; $display("FAIL arst_rdata act=%h exp=00", a.rdata); end
    #2;
    rst = 1'b0;
    a.w_en = 0;
    tick();
    a.w_en = 1; a.wdata = 8'h5A;
    tick();
    a.w_en = 0; a.r_en = 1;
    tick();
    a.r_en = 0;
    vectors++; if (a.rdata !== 8'h5A) begin miscompares++; $display("FAIL arst_new act=%h exp=5a", a.rdata); end
    vectors++; if (a.count !== 5'd0) begin miscompares++; $display("FAIL arst_new_count act=%0d exp=0", a.count); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul_full_empty();
    test_fwft();
    test_clr();
    test_async_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
